// File: rtl/multicycle_control.sv
// Sequencing controller for the multi-cycle MIPS datapath: instruction-step
// FSM, datapath mux selects/write strobes, memory handshake, retire counter.
module multicycle_control #(
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_write,
  output logic        i_or_d,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_2_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  pc_source,
  output logic        halted,
  output logic [3:0]  state,
  output logic [31:0] instr_retired
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXECUTE   = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ADDI_EX   = 4'd11,
    S_ADDI_WB   = 4'd12,
    S_TRAP      = 4'd13
  } state_e;

  // Pure state-decoded outputs; the last three flags are qualified by
  // mem_ready / zero outside the register to form ir_write and pc_write.
  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       i_or_d;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_2_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       halted;
    logic       fetch_strobe;
    logic       jump_write;
    logic       branch_write;
  } ctrl_t;

  state_e      state_q, state_d;
  ctrl_t       ctrl_q, ctrl_d;
  logic [31:0] instr_cnt_q, instr_cnt_d;
  logic        retire;

  function automatic ctrl_t decode(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_req      = 1'b1;
        c.alu_src_b    = 2'b01;
        c.fetch_strobe = 1'b1;
      end
      S_DECODE:    c.alu_src_b = 2'b11;
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        c.mem_req = 1'b1;
        c.i_or_d  = 1'b1;
      end
      S_MEM_WB: begin
        c.reg_write = 1'b1;
        c.mem_2_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        c.mem_req   = 1'b1;
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      S_EXECUTE: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      S_ALU_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a    = 1'b1;
        c.alu_op       = 2'b01;
        c.pc_source    = 2'b01;
        c.branch_write = 1'b1;
      end
      S_JUMP: begin
        c.pc_source  = 2'b10;
        c.jump_write = 1'b1;
      end
      S_ADDI_EX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_ADDI_WB:   c.reg_write = 1'b1;
      S_TRAP:      c.halted = 1'b1;
      default:     c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_IDLE:     state_d = S_FETCH;
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_ADDI:      state_d = S_ADDI_EX;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default:      state_d = ILLEGAL_TRAP ? S_TRAP : S_FETCH;
        endcase
      end
      S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ: if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WRITE: begin
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_MEM_WB, S_ALU_WB, S_BRANCH, S_JUMP, S_ADDI_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_EXECUTE:  state_d = S_ALU_WB;
      S_ADDI_EX:  state_d = S_ADDI_WB;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_IDLE;
    endcase
    // Registering the decode of the next state keeps outputs glitch-free
    // while still matching a Moore decode of the current state.
    ctrl_d      = decode(state_d);
    instr_cnt_d = instr_cnt_q + {31'd0, retire};
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= S_IDLE;
      ctrl_q      <= '0;
      instr_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign mem_req       = ctrl_q.mem_req;
  assign mem_write     = ctrl_q.mem_write;
  assign i_or_d        = ctrl_q.i_or_d;
  assign reg_write     = ctrl_q.reg_write;
  assign reg_dst       = ctrl_q.reg_dst;
  assign mem_2_reg     = ctrl_q.mem_2_reg;
  assign alu_src_a     = ctrl_q.alu_src_a;
  assign alu_src_b     = ctrl_q.alu_src_b;
  assign alu_op        = ctrl_q.alu_op;
  assign pc_source     = ctrl_q.pc_source;
  assign halted        = ctrl_q.halted;
  assign ir_write      = ctrl_q.fetch_strobe & mem_ready;
  assign pc_write      = (ctrl_q.fetch_strobe & mem_ready) | ctrl_q.jump_write
                       | (ctrl_q.branch_write & zero);
  assign state         = state_q;
  assign instr_retired = instr_cnt_q;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Sequencing controller for the multi-cycle variant of the MIPS datapath. It holds the instruction-step state and drives every datapath mux select and write strobe for ADD-class R-type, ADDI, LW, SW, BEQ and J. Instruction fetch and data accesses use a shared memory with a req/ready handshake. The block sits beside the register file, ALU and ALU-control; its `alu_op` output feeds the existing ALU-control decoder unchanged.

## Interface
- `ILLEGAL_TRAP`, default 1: 1 = an unknown opcode enters TRAP; 0 = an unknown opcode is dropped and fetch continues.
- `clk` in 1: single clock, rising edge.
- `arst_n` in 1: reset, asynchronous and active-low.
- `opcode` in 6: IR[31:26], valid from DECODE onward.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current access this cycle.
- `mem_req` out 1: memory access request.
- `mem_write` out 1: the access is a write (only with `mem_req`).
- `i_or_d` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `ir_write`, `pc_write`, `reg_write` out 1 each: write strobes.
- `reg_dst`, `mem_2_reg`, `alu_src_a` out 1 each: mux selects.
- `alu_src_b` out 2: 00 = B, 01 = const 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `alu_op` out 2: 00 = add, 01 = sub, 10 = R-type funct.
- `pc_source` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `halted` out 1: high in TRAP.
- `state` out 4: current state encoding, for debug.
- `instr_retired` out 32: count of completed instructions.

## Operation
- Moore decode from the state register. Exceptions: the strobes in FETCH depend on `mem_ready`, and `pc_write` in BRANCH depends on `zero`.
- Any output not listed for a state is 0.
- State encodings and behaviour:
  - **IDLE (0)**: all outputs 0. Goes to FETCH.
  - **FETCH (1)**: `mem_req`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_source`=00.
    - While `mem_ready`=0: hold state, `ir_write`=`pc_write`=0.
    - When `mem_ready`=1: `ir_write`=`pc_write`=1, go to DECODE.
  - **DECODE (2)**: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00 (precomputes the branch target). Dispatch on opcode:
    - 0x00 → EXECUTE
    - 0x08 → ADDI_EX
    - 0x23 or 0x2B → MEM_ADDR
    - 0x04 → BRANCH
    - 0x02 → JUMP
    - other → TRAP if `ILLEGAL_TRAP`=1, else FETCH.
  - **MEM_ADDR (3)**: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Goes to MEM_READ for LW, MEM_WRITE for SW.
  - **MEM_READ (4)**: `mem_req`=1, `i_or_d`=1. Holds until `mem_ready`, then MEM_WB.
  - **MEM_WB (5)**: `reg_write`=1, `reg_dst`=0, `mem_2_reg`=1. Goes to FETCH.
  - **MEM_WRITE (6)**: `mem_req`=1, `mem_write`=1, `i_or_d`=1. Holds until `mem_ready`, then FETCH.
  - **EXECUTE (7)**: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10. Goes to ALU_WB.
  - **ALU_WB (8)**: `reg_write`=1, `reg_dst`=1, `mem_2_reg`=0. Goes to FETCH.
  - **BRANCH (9)**: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_source`=01, `pc_write`=`zero`. Goes to FETCH.
  - **JUMP (10)**: `pc_source`=10, `pc_write`=1. Goes to FETCH.
  - **ADDI_EX (11)**: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Goes to ADDI_WB.
  - **ADDI_WB (12)**: `reg_write`=1, `reg_dst`=0. Goes to FETCH.
  - **TRAP (13)**: `halted`=1, all strobes 0. Held until reset.
  - Encodings 14–15: all outputs 0, next state IDLE.
- `instr_retired` increments by 1 on every transition into FETCH from MEM_WB, MEM_WRITE, ALU_WB, BRANCH, JUMP or ADDI_WB.
  - Dropped illegal opcodes do not count.
  - The counter wraps 0xFFFFFFFF → 0.
- Handshake rules:
  - `mem_req`, `mem_write` and `i_or_d` stay stable from assertion until the cycle `mem_ready`=1. The access completes in that cycle.
  - `mem_ready` is ignored in states without `mem_req`.

## Timing
- Reset: `arst_n` low forces state=IDLE and `instr_retired`=0 immediately (asynchronous). All outputs are 0, including `halted`.
- Reset asserted mid-access drops `mem_req` combinationally. No write strobe fires.
- First FETCH occurs on the first rising edge after `arst_n` deasserts.
- Cycles per instruction with zero-wait memory (`mem_ready` tied 1):
  - BEQ, J: 3
  - R-type, ADDI, SW: 4
  - LW: 5
- Each wait cycle with `mem_ready`=0 adds exactly 1 cycle in FETCH, MEM_READ or MEM_WRITE.
- `instr_retired` updates on the same edge as the final-state → FETCH transition.

## Test plan
- **Reset**: hold `arst_n`=0 mid-MEM_WRITE with `mem_ready`=0 → state=0, all outputs 0 without waiting for a clock edge. Release → FETCH with `mem_req`=1 next cycle.
- **Zero-wait mix**: `mem_ready`=1; sequence R, ADDI, LW, SW, BEQ(`zero`=1), J → 4+4+5+4+3+3=23 cycles after first FETCH, `instr_retired`=6. Per-state output values match Operation.
- **Wait states**: LW with `mem_ready` low 2 cycles in FETCH and 3 in MEM_READ → 10 cycles. `ir_write` pulses exactly once, `reg_write` exactly once.
- **Branch**: BEQ with `zero`=0 → `pc_write`=0 in BRANCH. With `zero`=1 → `pc_write`=1, `pc_source`=01.
- **Illegal opcode**: opcode 0x3F with `ILLEGAL_TRAP`=1 → TRAP, `halted`=1, no strobes for 20 cycles. With `ILLEGAL_TRAP`=0 → FETCH after DECODE, `instr_retired` unchanged.
- **Counter wrap**: force `instr_retired`=0xFFFFFFFF, retire J → 0x00000000.
